// File: rtl/sim_read_arbiter_pkg.sv
// Shared definitions for the simulation read-channel arbiter.
package sim_read_arbiter_pkg;

    localparam int unsigned BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sim_read_arbiter.sv
// Round-robin arbiter sharing one memory read channel between the ir and dr masters,
// with a single outstanding read and data returned only to the issuing requester.
module sim_read_arbiter
    import sim_read_arbiter_pkg::*;
#(
    parameter int unsigned BUS_W = BUS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ir_addr_valid,
    input  logic [BUS_W-1:0] ir_addr,
    output logic             ir_addr_ready,
    output logic             ir_data_valid,
    output logic [BUS_W-1:0] ir_data,
    input  logic             ir_data_ready,
    input  logic             dr_addr_valid,
    input  logic [BUS_W-1:0] dr_addr,
    output logic             dr_addr_ready,
    output logic             dr_data_valid,
    output logic [BUS_W-1:0] dr_data,
    input  logic             dr_data_ready,
    output logic             r_addr_valid,
    output logic [BUS_W-1:0] r_addr,
    input  logic             r_addr_ready,
    input  logic             r_data_valid,
    input  logic [BUS_W-1:0] r_data,
    output logic             r_data_ready,
    output logic             busy
);

    arb_state_t state, state_next;
    logic       owner, owner_next;
    logic       last, last_next;
    logic       winner;
    logic       sel;
    logic       req_valid;
    logic       owner_data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
        end
    end

    // Contended requests go to whichever master did not complete last.
    always_comb begin
        winner = 1'b0;
        if (ir_addr_valid && dr_addr_valid) begin
            winner = ~last;
        end else if (dr_addr_valid) begin
            winner = 1'b1;
        end
    end

    assign sel              = (state == ARB_IDLE) ? winner : owner;
    assign req_valid        = sel ? dr_addr_valid : ir_addr_valid;
    assign r_addr           = sel ? dr_addr : ir_addr;
    assign owner_data_ready = owner ? dr_data_ready : ir_data_ready;
    assign busy             = (state != ARB_IDLE);

    always_comb begin
        ir_addr_ready = 1'b0;
        dr_addr_ready = 1'b0;
        ir_data_valid = 1'b0;
        dr_data_valid = 1'b0;
        ir_data       = '0;
        dr_data       = '0;
        r_addr_valid  = 1'b0;
        r_data_ready  = 1'b0;
        state_next    = state;
        owner_next    = owner;
        last_next     = last;
        case (state)
            ARB_IDLE: begin
                // Leftover data (e.g. after a reset mid-read) is drained before any new address.
                if (r_data_valid) begin
                    r_data_ready = 1'b1;
                end else if (req_valid) begin
                    r_addr_valid  = 1'b1;
                    ir_addr_ready = ~winner & r_addr_ready;
                    dr_addr_ready = winner & r_addr_ready;
                    owner_next    = winner;
                    state_next    = r_addr_ready ? ARB_DATA : ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (!req_valid) begin
                    state_next = ARB_IDLE;
                end else begin
                    r_addr_valid  = 1'b1;
                    ir_addr_ready = ~owner & r_addr_ready;
                    dr_addr_ready = owner & r_addr_ready;
                    if (r_addr_ready) begin
                        state_next = ARB_DATA;
                    end
                end
            end
            ARB_DATA: begin
                r_data_ready = owner_data_ready;
                if (owner) begin
                    dr_data_valid = r_data_valid;
                    dr_data       = r_data;
                end else begin
                    ir_data_valid = r_data_valid;
                    ir_data       = r_data;
                end
                if (r_data_valid && owner_data_ready) begin
                    last_next  = owner;
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule
